// File: rtl/sdf_r2_stage_ctrl_pkg.sv
// Shared definitions for the radix-2 SDF stage controllers: butterfly mode
// encodings, the Q1.6 W32 twiddle table and the set of supported stage depths.
package sdf_r2_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_BFLY  = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // Twiddle components are Q1.6: 1.0 is represented as 64.
    localparam int TW_ROM = 8;
    localparam int W_ONE  = 64;

    // W32^e = cos(2*pi*e/32) - j*sin(2*pi*e/32), rounded to nearest, e = 0..15.
    localparam logic signed [TW_ROM-1:0] W32_RE [16] = '{
         8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
         8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63
    };
    localparam logic signed [TW_ROM-1:0] W32_IM [16] = '{
         8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
        -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12
    };

    // Feedback depths of the five stages of the 32-point pipeline.
    localparam int N_LEGAL = 5;
    localparam int LEGAL_DELAYS [N_LEGAL] = '{16, 8, 4, 2, 1};

    function automatic bit is_legal_delay(input int d);
        for (int k = 0; k < N_LEGAL; k++) begin
            if (LEGAL_DELAYS[k] == d) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/sdf_r2_stage_ctrl_w32_rom.sv
// Combinational W32 twiddle lookup: exponent e -> (WN_r, WN_i) in Q1.6.
module sdf_r2_stage_ctrl_w32_rom
    import sdf_r2_stage_ctrl_pkg::*;
(
    input  logic        [3:0]        e,
    output logic signed [TW_ROM-1:0] wn_r,
    output logic signed [TW_ROM-1:0] wn_i
);

    // Table lookup, no state.
    always_comb begin
        wn_r = W32_RE[e];
        wn_i = W32_IM[e];
    end

endmodule

// File: rtl/sdf_r2_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage. Registers the
// sample stream and, aligned with it, the butterfly mode, twiddle and valid.
module sdf_r2_stage_ctrl
    import sdf_r2_stage_ctrl_pkg::*;
#(
    parameter int DELAY = 8,
    parameter int DW    = 14,
    parameter int TW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic signed [DW-1:0] data_in_r,
    input  logic signed [DW-1:0] data_in_i,
    output logic                 valid_o,
    output logic        [1:0]    state,
    output logic signed [DW-1:0] data_out_r,
    output logic signed [DW-1:0] data_out_i,
    output logic signed [TW-1:0] WN_r,
    output logic signed [TW-1:0] WN_i,
    output logic                 err_o
);

    localparam int            PW       = (DELAY > 1) ? $clog2(DELAY) : 1;
    // An unsupported depth degrades to a unity twiddle rather than a bogus exponent.
    localparam int            E_STEP   = is_legal_delay(DELAY) ? (16 / DELAY) : 0;
    localparam logic [PW-1:0] POS_LAST = PW'(DELAY - 1);

    state_e               state_q, state_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 carry_q, carry_d;     // current FILL/DRAIN phase outputs stored differences
    logic                 vld_out_q, vld_out_d;
    logic                 err_q, err_d;
    logic signed [DW-1:0] dat_r_q, dat_r_d;
    logic signed [DW-1:0] dat_i_q, dat_i_d;
    logic signed [TW-1:0] wn_r_q, wn_r_d;
    logic signed [TW-1:0] wn_i_q, wn_i_d;

    logic                     pos_last;
    logic                     diff_phase;
    logic [3:0]               e_idx;
    logic signed [TW_ROM-1:0] rom_r, rom_i;

    // Phase sequencing: mode and position of the sample being registered this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        pos_d    = pos_q;
        carry_d  = carry_q;
        pos_last = (pos_q == POS_LAST);
        unique case (state_q)
            ST_IDLE: begin
                pos_d = '0;
                if (valid_i) begin
                    state_d = ST_FILL;
                    carry_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (pos_last) begin
                    state_d = ST_BFLY;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end
            ST_BFLY: begin
                if (pos_last) begin
                    state_d = valid_i ? ST_FILL : ST_DRAIN;
                    carry_d = 1'b1;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end
            ST_DRAIN: begin
                if (pos_last) begin
                    state_d = valid_i ? ST_FILL : ST_IDLE;
                    carry_d = 1'b0;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = '0;
            end
        endcase
    end

    // Registered outputs derived from the next phase so they line up with data_out.
    always_comb begin
        err_d      = (((state_d == ST_FILL) || (state_d == ST_BFLY)) && !valid_i)
                   || ((state_d == ST_DRAIN) && valid_i);
        diff_phase = ((state_d == ST_FILL) || (state_d == ST_DRAIN)) && carry_d;
        vld_out_d  = (state_d == ST_BFLY) || diff_phase;
        // e = 0 yields (64,0), so non-difference cycles need no separate mux.
        e_idx      = diff_phase ? 4'(int'(pos_d) * E_STEP) : 4'd0;
        wn_r_d     = TW'(rom_r);
        wn_i_d     = TW'(rom_i);
        dat_r_d    = err_d ? '0 : data_in_r;
        dat_i_d    = err_d ? '0 : data_in_i;
    end

    sdf_r2_stage_ctrl_w32_rom u_rom (
        .e    (e_idx),
        .wn_r (rom_r),
        .wn_i (rom_i)
    );

    // State and output registers; reset abandons any block in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            carry_q   <= 1'b0;
            vld_out_q <= 1'b0;
            err_q     <= 1'b0;
            dat_r_q   <= '0;
            dat_i_q   <= '0;
            wn_r_q    <= TW'(W_ONE);
            wn_i_q    <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            carry_q   <= carry_d;
            vld_out_q <= vld_out_d;
            err_q     <= err_d;
            dat_r_q   <= dat_r_d;
            dat_i_q   <= dat_i_d;
            wn_r_q    <= wn_r_d;
            wn_i_q    <= wn_i_d;
        end
    end

    assign valid_o    = vld_out_q;
    assign state      = state_q;
    assign data_out_r = dat_r_q;
    assign data_out_i = dat_i_q;
    assign WN_r       = wn_r_q;
    assign WN_i       = wn_i_q;
    assign err_o      = err_q;

endmodule
